// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding, default sizes
// and PC wrap arithmetic.
package ifetch_pkg;

    localparam int unsigned DefAddrW    = 8;
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefMemDepth = 64;
    localparam int unsigned DefBootAddr = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    // Next sequential PC inside [0, depth); wraps the last valid word back to 0.
    function automatic int unsigned pc_next(input int unsigned pc, input int unsigned depth);
        return (pc >= depth - 1) ? 0 : pc + 1;
    endfunction

endpackage

// File: rtl/ifetch_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush; registers the fetch output stream.
// Only built when IFETCH_OUTREG_EN is defined.
`ifdef IFETCH_OUTREG_EN
module ifetch_skid_buf #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             v0_q, v1_q;
    logic [WIDTH-1:0] d0_q, d1_q;
    logic             push, pop;

    // Ready depends only on the skid slot, so it is a pure register output.
    assign in_ready  = ~v1_q;
    assign out_valid = v0_q;
    assign out_data  = d0_q;
    assign push      = in_valid & ~v1_q;
    assign pop       = v0_q & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            d0_q <= '0;
            d1_q <= '0;
        end else if (flush) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    d0_q <= d1_q;
                    v0_q <= v1_q;
                    v1_q <= 1'b0;
                end
                2'b10: begin
                    if (!v0_q) begin
                        d0_q <= in_data;
                        v0_q <= 1'b1;
                    end else begin
                        d1_q <= in_data;
                        v1_q <= 1'b1;
                    end
                end
                2'b11: d0_q <= in_data;
                default: ;
            endcase
        end
    end

endmodule
`endif

// File: rtl/ifetch_sequencer.sv
// Fetch controller for a 1-cycle synchronous instruction memory: owns the PC, hands words to
// decode over valid/ready. Define IFETCH_OUTREG_EN for a registered (skid-buffered) output.
module ifetch_sequencer
    import ifetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned MEM_DEPTH = DefMemDepth,
    parameter int unsigned BOOT_ADDR = DefBootAddr
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] BootPc = ADDR_W'(BOOT_ADDR);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              rd_pend_q;
    logic              fault_q;
    logic              busy_q;
    logic              halted_q;

    logic              run;
    logic              redirect_bad;
    logic              fetch_valid;
    logic              fetch_ready;
    logic              fetch_xfer;
    logic              fetch_stall;

    assign run          = (state_q == StRun);
    assign redirect_bad = 32'(redirect_addr) >= MEM_DEPTH;

    // A word is on imem_data whenever a read was issued last edge; a redirect squashes it.
    assign fetch_valid = run & rd_pend_q & ~redirect_valid;
    assign fetch_xfer  = fetch_valid & fetch_ready;
    assign fetch_stall = fetch_valid & ~fetch_ready;

    // While stalled, re-present the held word's address so memory keeps returning it.
    assign imem_addr = fetch_stall ? fetch_pc_q : pc_q;

    assign busy   = busy_q;
    assign halted = halted_q;
    assign fault  = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= BootPc;
            fetch_pc_q <= '0;
            rd_pend_q  <= 1'b0;
            fault_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StHalt: begin
                    if (halt_req) begin
                        state_q  <= StHalt;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (start) begin
                        state_q   <= StRun;
                        pc_q      <= BootPc;
                        rd_pend_q <= 1'b0;
                        fault_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (halt_req) begin
                        state_q   <= StHalt;
                        rd_pend_q <= 1'b0;
                        busy_q    <= 1'b0;
                        halted_q  <= 1'b1;
                    end else if (redirect_valid) begin
                        rd_pend_q <= 1'b0;
                        if (redirect_bad) begin
                            state_q  <= StHalt;
                            fault_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q <= redirect_addr;
                        end
                    end else if (fetch_xfer || !rd_pend_q) begin
                        // Memory samples pc_q at this edge; its word appears next cycle.
                        rd_pend_q  <= 1'b1;
                        fetch_pc_q <= pc_q;
                        pc_q       <= ADDR_W'(pc_next(32'(pc_q), MEM_DEPTH));
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    rd_pend_q <= 1'b0;
                    busy_q    <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_OUTREG_EN
    logic                     flush;
    logic                     sk_valid;
    logic [ADDR_W+DATA_W-1:0] sk_data;

    assign flush = run & (halt_req | redirect_valid);

    ifetch_skid_buf #(
        .WIDTH (ADDR_W + DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (fetch_valid),
        .in_ready  (fetch_ready),
        .in_data   ({fetch_pc_q, imem_data}),
        .out_valid (sk_valid),
        .out_ready (inst_ready),
        .out_data  (sk_data)
    );

    assign inst_valid = sk_valid;
    assign inst_pc    = sk_data[ADDR_W+DATA_W-1:DATA_W];
    assign inst_data  = sk_valid ? sk_data[DATA_W-1:0] : '0;
`else
    assign fetch_ready = inst_ready;
    assign inst_valid  = fetch_valid;
    assign inst_pc     = fetch_pc_q;
    assign inst_data   = fetch_valid ? imem_data : '0;
`endif

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Self-checking bench for ifetch_sequencer with a 1-cycle synchronous memory holding
// word[i] = i ^ 8'hA5 and a stream-level reference model.
module tb_ifetch_sequencer;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       halt_req = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_addr = 8'h00;
    logic       inst_ready = 1'b0;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       inst_valid;
    logic [7:0] inst_data;
    logic [7:0] inst_pc;
    logic       busy;
    logic       halted;
    logic       fault;

    logic [7:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    ifetch_sequencer #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MEM_DEPTH (DEPTH),
        .BOOT_ADDR (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .busy           (busy),
        .halted         (halted),
        .fault          (fault)
    );

    function automatic logic [7:0] word_at(input int pc);
        logic [7:0] p;
        p = 8'(pc);
        return p ^ 8'hA5;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Stream with ready=1 until the given pc is presented (bounded).
    task automatic run_to(input int target);
        int n;
        n = 0;
        inst_ready = 1'b1;
        #1;
        while (!(inst_valid === 1'b1 && inst_pc === 8'(target)) && n < 200) begin
            tick();
            #1;
            n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL run_to: got pc=%0h valid=%0b, required pc=%0h", inst_pc, inst_valid, target);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        #1;
        n_cmp++; if (imem_addr !== 8'h00) begin n_err++; $display("FAIL reset_imem_addr: got %0h want 0", imem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", inst_valid); end
        n_cmp++; if (inst_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %0h want 0", inst_data); end
        n_cmp++; if (inst_pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %0h want 0", inst_pc); end
        n_cmp++; if ({busy, halted, fault} !== 3'b000) begin n_err++; $display("FAIL reset_status: got %b want 000", {busy, halted, fault}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start_stream();
        start = 1'b1;
        inst_ready = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0 || busy !== 1'b1 || imem_addr !== 8'h00) begin
            n_err++; $display("FAIL start_e0: got valid=%0b busy=%0b addr=%0h want 0/1/0", inst_valid, busy, imem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'(k) || inst_data !== word_at(k)) begin
                n_err++; $display("FAIL start_stream[%0d]: got v=%0b pc=%0h d=%0h want 1/%0h/%0h",
                                  k, inst_valid, inst_pc, inst_data, k, word_at(k));
            end
        end
    endtask

    task automatic test_stall();
        run_to(5);
        inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h05 || inst_data !== 8'hA0 || imem_addr !== 8'h05) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%0b pc=%0h d=%0h a=%0h want 1/5/a0/5",
                                  k, inst_valid, inst_pc, inst_data, imem_addr);
            end
            tick();
        end
        inst_ready = 1'b1;
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h05) begin
            n_err++; $display("FAIL stall_release: got v=%0b pc=%0h want 1/5", inst_valid, inst_pc);
        end
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h06 || inst_data !== 8'hA3) begin
            n_err++; $display("FAIL stall_next: got v=%0b pc=%0h d=%0h want 1/6/a3", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_wrap();
        run_to(62);
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'd63 || inst_data !== 8'h9A) begin
            n_err++; $display("FAIL wrap_63: got v=%0b pc=%0h d=%0h want 1/3f/9a", inst_valid, inst_pc, inst_data);
        end
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'd0 || inst_data !== 8'hA5) begin
            n_err++; $display("FAIL wrap_0: got v=%0b pc=%0h d=%0h want 1/0/a5", inst_valid, inst_pc, inst_data);
        end
    endtask

    task automatic test_redirect();
        run_to(3);
        redirect_valid = 1'b1;
        redirect_addr  = 8'h20;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_squash: got %0b want 0", inst_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0 || imem_addr !== 8'h20) begin
            n_err++; $display("FAIL redir_bubble: got v=%0b a=%0h want 0/20", inst_valid, imem_addr);
        end
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h20 || inst_data !== 8'h85) begin
            n_err++; $display("FAIL redir_target: got v=%0b pc=%0h d=%0h want 1/20/85", inst_valid, inst_pc, inst_data);
        end
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h21 || inst_data !== 8'h84) begin
            n_err++; $display("FAIL redir_next: got v=%0b pc=%0h d=%0h want 1/21/84", inst_valid, inst_pc, inst_data);
        end
    endtask

    // Random ready and random in-range redirects against an expected-stream model.
    task automatic test_random();
        int  exp_pc;
        bit  bubble;
        bit  rdy;
        bit  redir;
        int  tgt;
        exp_pc = 8'h21;
        bubble = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = int'($urandom_range(0, DEPTH - 1));
            inst_ready     = rdy;
            redirect_valid = redir;
            redirect_addr  = 8'(tgt);
            #1;
            n_cmp++;
            if (redir || bubble) begin
                if (inst_valid !== 1'b0) begin
                    n_err++; $display("FAIL rand_bubble[%0d]: got valid=%0b want 0", c, inst_valid);
                end
            end else begin
                if (inst_valid !== 1'b1 || inst_pc !== 8'(exp_pc) || inst_data !== word_at(exp_pc)) begin
                    n_err++; $display("FAIL rand_stream[%0d]: got v=%0b pc=%0h d=%0h want 1/%0h/%0h",
                                      c, inst_valid, inst_pc, inst_data, exp_pc, word_at(exp_pc));
                end
                if (rdy) exp_pc = (exp_pc + 1) % DEPTH;
            end
            bubble = redir;
            if (redir) exp_pc = tgt;
            tick();
        end
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
    endtask

    task automatic test_bad_redirect();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h50;
        #1;
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL bad_squash: got %0b want 0", inst_valid); end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++; if ({fault, halted, busy, inst_valid} !== 4'b1100) begin
            n_err++; $display("FAIL bad_fault: got f/h/b/v=%b want 1100", {fault, halted, busy, inst_valid});
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++; if ({fault, halted, busy} !== 3'b001 || imem_addr !== 8'h00) begin
            n_err++; $display("FAIL restart: got f/h/b=%b a=%0h want 001/0", {fault, halted, busy}, imem_addr);
        end
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00) begin
            n_err++; $display("FAIL restart_first: got v=%0b pc=%0h want 1/0", inst_valid, inst_pc);
        end
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h10;
        tick();
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++; if (halted !== 1'b1 || fault !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 8'h01) begin
                n_err++; $display("FAIL halt_over_redir[%0d]: got h=%0b f=%0b v=%0b a=%0h want 1/0/0/1",
                                  k, halted, fault, inst_valid, imem_addr);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(4);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if ({inst_valid, busy, halted, fault} !== 4'b0000 || imem_addr !== 8'h00
                     || inst_pc !== 8'h00 || inst_data !== 8'h00) begin
            n_err++; $display("FAIL async_reset: got v/b/h/f=%b a=%0h pc=%0h d=%0h want 0000/0/0/0",
                              {inst_valid, busy, halted, fault}, imem_addr, inst_pc, inst_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        n_cmp++; if (inst_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL post_reset_e0: got v=%0b b=%0b want 0/1", inst_valid, busy);
        end
        tick();
        #1;
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 8'h00 || inst_data !== 8'hA5) begin
            n_err++; $display("FAIL post_reset_first: got v=%0b pc=%0h d=%0h want 1/0/a5", inst_valid, inst_pc, inst_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        test_reset();
        test_start_stream();
        test_stall();
        test_wrap();
        test_redirect();
        test_random();
        test_bad_redirect();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
